// File: rtl/gather_read_dma_desc_engine.sv
// gather_read_dma_desc_engine: fetches a descriptor table, dispatches non-zero descriptors, then interrupts.
// Optional GATHER_DMA_STATS_EN adds stat_desc_cnt/stat_bytes dispatch counters.
module gather_read_dma_desc_engine #(
  parameter int P_DESC_PER_BEAT = 2,
  parameter int P_FIFO_BITS = 5,
  parameter int P_LEN_BITS = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  start,
  input  logic [31:0]           tbl_host_addr,
  input  logic [11:0]           tbl_len,
  input  logic [P_LEN_BITS-1:0] dev_base,
  output logic                  busy,
  output logic                  err,
  output logic [31:0]           rd_addr,
  output logic [9:0]            rd_len,
  output logic                  rd_valid,
  input  logic                  rd_done,
  input  logic [7:0]            cur_tag,
  input  logic [7:0]            cpl_tag,
  input  logic [127:0]          cpl_data,
  input  logic                  cpl_valid,
  output logic [31:0]           sub_host_addr,
  output logic [P_LEN_BITS-1:0] sub_dev_addr,
  output logic [P_LEN_BITS-1:0] sub_len,
  output logic                  sub_start,
  input  logic                  sub_done,
  input  logic                  sub_idle,
  output logic                  int_valid,
  input  logic                  int_done
`ifdef GATHER_DMA_STATS_EN
  ,
  output logic [15:0]           stat_desc_cnt,
  output logic [31:0]           stat_bytes
`endif
);
  localparam int CW = P_FIFO_BITS + 1;
  typedef enum logic [2:0] {IDLE, FETCH, POP, SCAN, RUN, DRAIN, INT} state_t;
  state_t state, state_n;
  logic [127:0] mem [2**P_FIFO_BITS];
  logic [127:0] beat;
  logic [255:0] beat_x;
  logic [63:0] slot_w;
  logic [CW-1:0] wr_ptr, rd_ptr, beats, beats_left;
  logic [7:0] tag;
  logic [2:0] slot, slot_n, idx;
  logic [31:0] idx_host;
  logic [P_LEN_BITS-1:0] len_t, dev, dev_n;
  logic hot, start_ok, accept, cap, fifo_empty, step, beat_end, launch;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign start_ok = tbl_len != 12'd0 && tbl_len[3:0] == 4'd0 && 32'(tbl_len[11:4]) <= (32'd1 << P_FIFO_BITS);
  assign accept = state == IDLE && start && start_ok;
  assign cap = hot && cpl_valid && cpl_tag == tag;
  assign fifo_empty = wr_ptr == rd_ptr;
  assign busy = state != IDLE;
  assign rd_valid = state == FETCH;
  assign int_valid = state == INT;
  // RUN looks ahead to the next slot so an adjacent descriptor launches on the sub_done edge
  assign idx = state == RUN ? slot + 3'd1 : slot;
  assign step = state == SCAN || (state == RUN && sub_done);
  assign beat_x = {128'd0, beat};
  assign slot_w = beat_x[{idx[1:0], 6'd0} +: 64];
  assign idx_host = bswap(slot_w[31:0]);
  assign len_t = P_LEN_BITS'(bswap(slot_w[63:32]));
  assign beat_end = idx >= 3'(P_DESC_PER_BEAT);
  assign dev_n = state == RUN ? dev + sub_len : dev;

  always_comb begin
    state_n = state;
    slot_n = slot;
    launch = 1'b0;
    case (state)
      IDLE: state_n = accept ? FETCH : IDLE;
      FETCH: state_n = rd_done ? POP : FETCH;
      POP: if (!fifo_empty) begin
        state_n = SCAN;
        slot_n = '0;
      end
      SCAN, RUN: if (step) begin
        if (beat_end) state_n = beats_left == CW'(1) ? DRAIN : POP;
        else if (len_t != '0) begin
          state_n = RUN;
          slot_n = idx;
          launch = 1'b1;
        end else begin
          state_n = SCAN;
          slot_n = idx + 3'd1;
        end
      end
      DRAIN: state_n = sub_idle ? INT : DRAIN;
      INT: state_n = int_done ? IDLE : INT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk)
    if (cap) mem[wr_ptr[P_FIFO_BITS-1:0]] <= cpl_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      slot <= '0;
      err <= 1'b0;
      rd_addr <= '0;
      rd_len <= '0;
      tag <= '0;
      hot <= 1'b0;
      beats <= '0;
      beats_left <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      beat <= '0;
      dev <= '0;
      sub_host_addr <= '0;
      sub_dev_addr <= '0;
      sub_len <= '0;
      sub_start <= 1'b0;
`ifdef GATHER_DMA_STATS_EN
      stat_desc_cnt <= '0;
      stat_bytes <= '0;
`endif
    end else begin
      state <= state_n;
      slot <= slot_n;
      err <= state == IDLE && start && !start_ok;
      sub_start <= launch;
      if (accept) begin
        rd_addr <= tbl_host_addr;
        rd_len <= tbl_len[11:2];
        tag <= cur_tag;
        hot <= 1'b1;
        beats <= CW'(tbl_len[11:4]);
        beats_left <= CW'(tbl_len[11:4]);
        wr_ptr <= '0;
        rd_ptr <= '0;
        dev <= dev_base;
`ifdef GATHER_DMA_STATS_EN
        stat_desc_cnt <= '0;
        stat_bytes <= '0;
`endif
      end
      if (cap) begin
        wr_ptr <= wr_ptr + CW'(1);
        if (wr_ptr + CW'(1) == beats) hot <= 1'b0;
      end
      if (state == POP && !fifo_empty) begin
        beat <= mem[rd_ptr[P_FIFO_BITS-1:0]];
        rd_ptr <= rd_ptr + CW'(1);
      end
      if (step && beat_end) beats_left <= beats_left - CW'(1);
      if (state == RUN && sub_done) dev <= dev_n;
      if (launch) begin
        sub_host_addr <= idx_host;
        sub_dev_addr <= dev_n;
        sub_len <= len_t;
`ifdef GATHER_DMA_STATS_EN
        stat_desc_cnt <= stat_desc_cnt + 16'd1;
        stat_bytes <= stat_bytes + 32'(len_t);
`endif
      end
    end
  end
endmodule

// File: tb/tb_gather_read_dma_desc_engine.sv
// tb_gather_read_dma_desc_engine: directed bench for the descriptor engine (default parameters).
module tb_gather_read_dma_desc_engine;
  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic start = 1'b0, rd_done = 1'b0, cpl_valid = 1'b0, sub_done = 1'b0, sub_idle = 1'b0, int_done = 1'b0;
  logic [31:0] tbl_host_addr = '0, dev_base = '0;
  logic [11:0] tbl_len = '0;
  logic [7:0] cur_tag = '0, cpl_tag = '0;
  logic [127:0] cpl_data = '0;
  logic busy, err, rd_valid, sub_start, int_valid;
  logic [31:0] rd_addr, sub_host_addr, sub_dev_addr, sub_len;
  logic [9:0] rd_len;
`ifdef GATHER_DMA_STATS_EN
  logic [15:0] stat_desc_cnt;
  logic [31:0] stat_bytes;
`endif
  int checks = 0, errors = 0, sub_cnt = 0;

  gather_read_dma_desc_engine dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .start(start), .tbl_host_addr(tbl_host_addr), .tbl_len(tbl_len),
    .dev_base(dev_base), .busy(busy), .err(err), .rd_addr(rd_addr), .rd_len(rd_len), .rd_valid(rd_valid),
    .rd_done(rd_done), .cur_tag(cur_tag), .cpl_tag(cpl_tag), .cpl_data(cpl_data), .cpl_valid(cpl_valid),
    .sub_host_addr(sub_host_addr), .sub_dev_addr(sub_dev_addr), .sub_len(sub_len), .sub_start(sub_start),
    .sub_done(sub_done), .sub_idle(sub_idle), .int_valid(int_valid), .int_done(int_done)
`ifdef GATHER_DMA_STATS_EN
    , .stat_desc_cnt(stat_desc_cnt), .stat_bytes(stat_bytes)
`endif
  );

  always #5 i_clk = ~i_clk;
  always @(negedge i_clk) if (sub_start) sub_cnt <= sub_cnt + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  function automatic logic [31:0] bsw(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
  function automatic logic [63:0] desc(input logic [31:0] h, input logic [31:0] l);
    return {bsw(l), bsw(h)};
  endfunction

  task automatic do_start(input logic [31:0] a, input logic [11:0] l, input logic [31:0] b, input logic [7:0] t);
    @(negedge i_clk);
    start = 1'b1; tbl_host_addr = a; tbl_len = l; dev_base = b; cur_tag = t;
    @(negedge i_clk);
    start = 1'b0;
  endtask
  task automatic ack_rd;
    rd_done = 1'b1;
    @(negedge i_clk);
    rd_done = 1'b0;
  endtask
  task automatic send(input logic [7:0] t, input logic [127:0] d);
    cpl_tag = t; cpl_data = d; cpl_valid = 1'b1;
    @(negedge i_clk);
    cpl_valid = 1'b0;
  endtask
  task automatic pulse_done;
    @(negedge i_clk);
    sub_done = 1'b1;
    @(negedge i_clk);
    sub_done = 1'b0;
  endtask
  task automatic ack_int;
    int_done = 1'b1;
    @(negedge i_clk);
    int_done = 1'b0;
  endtask
  task automatic wait_sub(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sub_start) begin ok = 1'b1; break; end
      @(negedge i_clk);
    end
  endtask
  task automatic wait_int(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (int_valid) begin ok = 1'b1; break; end
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge i_clk);
    checks++; if ({busy, err, rd_valid, sub_start, int_valid} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {busy, err, rd_valid, sub_start, int_valid}); end
    checks++; if ({rd_addr, sub_host_addr, sub_dev_addr, sub_len} !== 128'd0) begin errors++; $display("FAIL reset_data got %h want 0", {rd_addr, sub_host_addr, sub_dev_addr, sub_len}); end
    i_rst_n = 1'b1;
  endtask

  task automatic test_four_desc;
    bit ok;
    int s0 = sub_cnt;
    do_start(32'h1000_0000, 12'd32, 32'h8000, 8'h11);
    checks++; if (rd_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL four_rd_valid got %b%b want 11", rd_valid, busy); end
    checks++; if (rd_addr !== 32'h1000_0000 || rd_len !== 10'd8) begin errors++; $display("FAIL four_rd_req got %h/%0d want 10000000/8", rd_addr, rd_len); end
    ack_rd;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL four_rd_drop got %b want 0", rd_valid); end
    send(8'h11, {desc(32'h2000_1000, 32'h100), desc(32'h2000_0000, 32'h100)});
    send(8'h11, {desc(32'h2000_3000, 32'h100), desc(32'h2000_2000, 32'h100)});
    for (int k = 0; k < 4; k++) begin
      wait_sub(ok);
      checks++; if (!ok) begin errors++; $display("FAIL four_sub%0d_timeout got none want sub_start", k); end
      checks++; if (sub_host_addr !== 32'h2000_0000 + 32'(k) * 32'h1000 || sub_dev_addr !== 32'h8000 + 32'(k) * 32'h100 || sub_len !== 32'h100)
        begin errors++; $display("FAIL four_sub%0d got %h/%h/%h want %h/%h/100", k, sub_host_addr, sub_dev_addr, sub_len, 32'h2000_0000 + 32'(k) * 32'h1000, 32'h8000 + 32'(k) * 32'h100); end
      pulse_done;
      if (k == 0 || k == 2) begin
        checks++; if (sub_start !== 1'b1) begin errors++; $display("FAIL four_adjacent_latency%0d got %b want 1", k, sub_start); end
      end
    end
    repeat (3) @(negedge i_clk);
    checks++; if (int_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL four_drain got int=%b busy=%b want 0/1", int_valid, busy); end
    checks++; if (sub_cnt - s0 !== 4) begin errors++; $display("FAIL four_count got %0d want 4", sub_cnt - s0); end
    sub_idle = 1'b1;
    wait_int(ok);
    checks++; if (!ok) begin errors++; $display("FAIL four_int got none want int_valid"); end
`ifdef GATHER_DMA_STATS_EN
    checks++; if (stat_desc_cnt !== 16'd4 || stat_bytes !== 32'h400) begin errors++; $display("FAIL four_stats got %0d/%h want 4/400", stat_desc_cnt, stat_bytes); end
`endif
    ack_int;
    checks++; if (int_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL four_idle got int=%b busy=%b want 0/0", int_valid, busy); end
    sub_idle = 1'b0;
  endtask

  task automatic test_zero_skip;
    bit ok;
    int s0 = sub_cnt;
    do_start(32'h3000_0000, 12'd32, 32'hABC0, 8'h22);
    ack_rd;
    send(8'h22, {32'h4000_0000, 32'h7856_3412, 64'd0});
    send(8'h23, {desc(32'h5000_0000, 32'h10), desc(32'h5000_0000, 32'h10)});
    send(8'h22, 128'd0);
    wait_sub(ok);
    checks++; if (!ok) begin errors++; $display("FAIL skip_timeout got none want sub_start"); end
    checks++; if (sub_host_addr !== 32'h1234_5678) begin errors++; $display("FAIL skip_byteswap got %h want 12345678", sub_host_addr); end
    checks++; if (sub_len !== 32'h40 || sub_dev_addr !== 32'hABC0) begin errors++; $display("FAIL skip_sub got %h/%h want 40/abc0", sub_len, sub_dev_addr); end
    pulse_done;
    send(8'h22, {desc(32'h6000_0000, 32'h20), desc(32'h6000_0000, 32'h20)});
    repeat (8) @(negedge i_clk);
    checks++; if (sub_cnt - s0 !== 1) begin errors++; $display("FAIL skip_count got %0d want 1", sub_cnt - s0); end
    checks++; if (int_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL skip_wait_idle got int=%b busy=%b want 0/1", int_valid, busy); end
    sub_idle = 1'b1;
    wait_int(ok);
    checks++; if (!ok) begin errors++; $display("FAIL skip_int got none want int_valid"); end
    ack_int;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL skip_idle got %b want 0", busy); end
    sub_idle = 1'b0;
  endtask

  task automatic test_bad_len;
    logic [11:0] lens [3] = '{12'd24, 12'd0, 12'd528};
    foreach (lens[i]) begin
      do_start(32'h9000_0000, lens[i], 32'h0, 8'h01);
      checks++; if (err !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL bad_len%0d got err=%b busy=%b rd=%b want 1/0/0", lens[i], err, busy, rd_valid); end
      @(negedge i_clk);
      checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bad_len%0d_pulse got err=%b busy=%b want 0/0", lens[i], err, busy); end
    end
    do_start(32'h9000_0000, 12'd512, 32'h0, 8'h01);
    checks++; if (err !== 1'b0 || rd_valid !== 1'b1 || rd_len !== 10'd128) begin errors++; $display("FAIL max_len got err=%b rd=%b len=%0d want 0/1/128", err, rd_valid, rd_len); end
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_start_busy;
    bit ok;
    int s0 = sub_cnt;
    do_start(32'h4000_0000, 12'd16, 32'h100, 8'h33);
    start = 1'b1; tbl_host_addr = 32'h5555_0000; tbl_len = 12'd24;
    @(negedge i_clk);
    start = 1'b0;
    checks++; if (err !== 1'b0 || rd_addr !== 32'h4000_0000 || rd_valid !== 1'b1) begin errors++; $display("FAIL busy_start got err=%b addr=%h rd=%b want 0/40000000/1", err, rd_addr, rd_valid); end
    ack_rd;
    send(8'h33, 128'd0);
    repeat (6) @(negedge i_clk);
    checks++; if (sub_cnt - s0 !== 0 || int_valid !== 1'b0) begin errors++; $display("FAIL zero_table got subs=%0d int=%b want 0/0", sub_cnt - s0, int_valid); end
    sub_idle = 1'b1;
    wait_int(ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_table_int got none want int_valid"); end
    ack_int;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_table_idle got %b want 0", busy); end
    sub_idle = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    bit ok;
    logic [127:0] tbl = {desc(32'h7200_0000, 32'h30), desc(32'h7100_0000, 32'h80)};
    do_start(32'h7000_0000, 12'd16, 32'h2000, 8'h44);
    ack_rd;
    send(8'h44, tbl);
    wait_sub(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_run_timeout got none want sub_start"); end
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checks++; if ({busy, sub_start, rd_valid, int_valid} !== 4'b0 || {sub_host_addr, sub_dev_addr, sub_len} !== 96'd0)
      begin errors++; $display("FAIL rst_run_outputs got %b/%h want 0", {busy, sub_start, rd_valid, int_valid}, {sub_host_addr, sub_dev_addr, sub_len}); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    do_start(32'h7000_0000, 12'd16, 32'h3000, 8'h45);
    checks++; if (rd_valid !== 1'b1 || rd_len !== 10'd4) begin errors++; $display("FAIL rst_restart got rd=%b len=%0d want 1/4", rd_valid, rd_len); end
    ack_rd;
    send(8'h45, tbl);
    wait_sub(ok);
    checks++; if (!ok || sub_host_addr !== 32'h7100_0000 || sub_dev_addr !== 32'h3000 || sub_len !== 32'h80)
      begin errors++; $display("FAIL rst_sub0 got %b %h/%h/%h want 1 71000000/3000/80", ok, sub_host_addr, sub_dev_addr, sub_len); end
    pulse_done;
    wait_sub(ok);
    checks++; if (!ok || sub_host_addr !== 32'h7200_0000 || sub_dev_addr !== 32'h3080 || sub_len !== 32'h30)
      begin errors++; $display("FAIL rst_sub1 got %b %h/%h/%h want 1 72000000/3080/30", ok, sub_host_addr, sub_dev_addr, sub_len); end
    pulse_done;
    sub_idle = 1'b1;
    wait_int(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_int got none want int_valid"); end
    ack_int;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle got %b want 0", busy); end
    sub_idle = 1'b0;
  endtask

  initial begin
    test_reset;
    test_four_desc;
    test_zero_skip;
    test_bad_len;
    test_start_busy;
    test_reset_mid_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
